uart_hex_word_tx: RTL and testbench

Downstream stage of the UART input manager. Consumes its 16-bit hex word and one-cycle ready pulse. Echoes the word back over UART TX as 4 ASCII hex characters, with an optional CR LF after them. Used as the board-level echo/readback path, driving the RsTx pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 105 ++++++++++
 rtl/uart_hex_word_tx.sv | 85 ++++++++
 tb/tb_uart_hex_word_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART hex-word transmitter: serializer states, ASCII
// control characters and small helper functions.
package uart_pkg;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   function automatic int unsigned clks_per_bit(int unsigned clock_rate,
                                                int unsigned baud_rate);
      return clock_rate / baud_rate;
   endfunction

   // Uppercase-only hex digit to ASCII.
   function automatic logic [7:0] hex_to_ascii(logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. A start request in the final stop-bit cycle chains the
// next frame with no idle gap.
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       tx_o
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

   uart_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            bit_end;

   assign bit_end = (cnt_q == CntLast);

   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_o  = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (start_i) begin
               state_d = StStart;
               shift_d = data_i;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               done_o = 1'b1;
               if (start_i) begin
                  state_d = StStart;
                  shift_d = data_i;
                  tx_d    = 1'b0;
               end else begin
                  state_d = StIdle;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = busy_q;

endmodule

// File: rtl/uart_hex_word_tx.sv
// Echoes a hex word over UART as ASCII digits (nibble 0 first), optionally followed by
// CR LF. Requests arriving while a word is in flight are dropped and flagged.
module uart_hex_word_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_RATE  = 100_000_000,
   parameter int unsigned BAUD_RATE   = 9600,
   parameter int unsigned DIGIT_COUNT = 4,
   parameter int unsigned APPEND_CRLF = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DIGIT_COUNT*4-1:0] in,
   input  logic                     ready_in,
   output logic                     RsTx,
   output logic                     busy,
   output logic                     dropped
);

   localparam int unsigned ClksPerBit = clks_per_bit(CLOCK_RATE, BAUD_RATE);
   localparam int unsigned WordW      = DIGIT_COUNT * 4;
   localparam int unsigned NChars     = DIGIT_COUNT + 2 * APPEND_CRLF;
   localparam int unsigned IdxW       = (NChars > 1) ? $clog2(NChars) : 1;

   logic [WordW-1:0] word_q, word_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic             dropped_q, dropped_d;
   logic             accept, last_char, byte_start, byte_done;
   logic [7:0]       byte_data;

   function automatic logic [7:0] char_at(logic [WordW-1:0] w, int unsigned i);
      if (i < DIGIT_COUNT) return hex_to_ascii(4'(w >> (4 * i)));
      else if (i == DIGIT_COUNT) return CR;
      else return LF;
   endfunction

   assign accept    = ready_in && !busy;
   assign last_char = (idx_q == IdxW'(NChars - 1));

   always_comb begin
      word_d     = word_q;
      idx_d      = idx_q;
      byte_start = 1'b0;
      byte_data  = 8'h00;
      dropped_d  = ready_in && busy;
      if (accept) begin
         word_d     = in;
         idx_d      = '0;
         byte_start = 1'b1;
         byte_data  = char_at(in, 0);
      end else if (byte_done && !last_char) begin
         // Present the next character in the stop bit's final cycle for zero-gap chaining.
         idx_d      = idx_q + 1'b1;
         byte_start = 1'b1;
         byte_data  = char_at(word_q, 32'(idx_q) + 32'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_q    <= '0;
         idx_q     <= '0;
         dropped_q <= 1'b0;
      end else begin
         word_q    <= word_d;
         idx_q     <= idx_d;
         dropped_q <= dropped_d;
      end
   end

   assign dropped = dropped_q;

   uart_tx_byte #(
      .CLKS_PER_BIT (ClksPerBit)
   ) u_tx_byte (
      .clk     (clk),
      .reset   (reset),
      .start_i (byte_start),
      .data_i  (byte_data),
      .busy_o  (busy),
      .done_o  (byte_done),
      .tx_o    (RsTx)
   );

endmodule

// File: tb/tb_uart_hex_word_tx.sv
// Directed bench for uart_hex_word_tx at 16 clocks per bit, with and without CR LF.
module tb_uart_hex_word_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] in_a = 16'h0, in_b = 16'h0;
   logic        rdy_a = 1'b0, rdy_b = 1'b0;
   logic        tx_a, busy_a, drop_a;
   logic        tx_b, busy_b, drop_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_hex_word_tx #(
      .CLOCK_RATE  (16),
      .BAUD_RATE   (1),
      .DIGIT_COUNT (4),
      .APPEND_CRLF (1)
   ) u_dut_crlf (
      .clk      (clk),
      .reset    (reset),
      .in       (in_a),
      .ready_in (rdy_a),
      .RsTx     (tx_a),
      .busy     (busy_a),
      .dropped  (drop_a)
   );

   uart_hex_word_tx #(
      .CLOCK_RATE  (16),
      .BAUD_RATE   (1),
      .DIGIT_COUNT (4),
      .APPEND_CRLF (0)
   ) u_dut_plain (
      .clk      (clk),
      .reset    (reset),
      .in       (in_b),
      .ready_in (rdy_b),
      .RsTx     (tx_b),
      .busy     (busy_b),
      .dropped  (drop_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic tx_of(bit sel);
      return sel ? tx_b : tx_a;
   endfunction

   function automatic logic busy_of(bit sel);
      return sel ? busy_b : busy_a;
   endfunction

   function automatic logic drop_of(bit sel);
      return sel ? drop_b : drop_a;
   endfunction

   task automatic drive(bit sel, logic rdy, logic [15:0] w);
      if (sel) begin
         rdy_b = rdy;
         in_b  = w;
      end else begin
         rdy_a = rdy;
         in_a  = w;
      end
   endtask

   task automatic send_word(bit sel, logic [15:0] w);
      drive(sel, 1'b1, w);
      tick();
      drive(sel, 1'b0, w);
   endtask

   // Entered one cycle after the accepting edge; returns after busy should have fallen.
   task automatic run_word(bit sel, logic [7:0] exp [6], int n, int drop_at, string name);
      logic [9:0] frames [6];
      int drops = 0;
      int busy_low = 0;
      for (int c = 0; c < n * 160; c++) begin
         if (c == 0) begin
            checks++;
            if (tx_of(sel) !== 1'b0) begin
               errors++;
               $display("FAIL %s start latency: RsTx=%b required 0", name, tx_of(sel));
            end
         end
         if (drop_at >= 0 && c == drop_at) drive(sel, 1'b1, 16'hFFFF);
         if (drop_at >= 0 && c == drop_at + 1) drive(sel, 1'b0, 16'hFFFF);
         if (busy_of(sel) !== 1'b1) busy_low++;
         if (drop_of(sel) === 1'b1) drops++;
         if (c % 16 == 8) frames[c / 160][(c % 160) / 16] = tx_of(sel);
         tick();
      end
      for (int f = 0; f < n; f++) begin
         checks++;
         if (frames[f] !== {1'b1, exp[f], 1'b0}) begin
            errors++;
            $display("FAIL %s frame %0d: got %b required %b", name, f, frames[f],
                     {1'b1, exp[f], 1'b0});
         end
      end
      checks++;
      if (busy_low != 0) begin
         errors++;
         $display("FAIL %s busy width: %0d low cycles within %0d required 0", name, busy_low,
                  n * 160);
      end
      checks++;
      if (busy_of(sel) !== 1'b0 || tx_of(sel) !== 1'b1) begin
         errors++;
         $display("FAIL %s end of word: busy=%b RsTx=%b required busy=0 RsTx=1", name,
                  busy_of(sel), tx_of(sel));
      end
      checks++;
      if (drops != ((drop_at >= 0) ? 1 : 0)) begin
         errors++;
         $display("FAIL %s dropped pulses: got %0d required %0d", name, drops,
                  (drop_at >= 0) ? 1 : 0);
      end
   endtask

   task automatic check_idle(string name);
      checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || drop_a !== 1'b0) begin
         errors++;
         $display("FAIL %s: RsTx=%b busy=%b dropped=%b required 1 0 0", name, tx_a, busy_a,
                  drop_a);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("reset held");
      end
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_idle("after reset");
      end
      reset = 1'b1;
      drive(1'b0, 1'b1, 16'h1234);
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, 16'h1234);
      check_idle("reset with ready_in");
      tick();
      check_idle("reset with ready_in next");
   endtask

   task automatic test_word();
      logic [7:0] e [6];
      e = '{8'h46, 8'h31, 8'h41, 8'h33, 8'h0D, 8'h0A};
      send_word(1'b0, 16'h3A1F);
      run_word(1'b0, e, 6, -1, "word 3A1F");
      tick();
      send_word(1'b0, 16'h3A1F);
      run_word(1'b0, e, 6, 100, "word 3A1F overflow");
   endtask

   task automatic test_no_crlf();
      logic [7:0] e [6];
      e = '{8'h39, 8'h30, 8'h30, 8'h30, 8'h00, 8'h00};
      send_word(1'b1, 16'h0009);
      run_word(1'b1, e, 4, -1, "no crlf 0009");
   endtask

   task automatic test_reset_mid();
      logic [7:0] e [6];
      e = '{8'h46, 8'h45, 8'h45, 8'h42, 8'h0D, 8'h0A};
      tick();
      send_word(1'b0, 16'h0000);
      repeat (50) tick();
      checks++;
      if (tx_a !== 1'b0) begin
         errors++;
         $display("FAIL mid-word data bit: RsTx=%b required 0", tx_a);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("mid-word reset");
      tick();
      check_idle("mid-word reset hold");
      send_word(1'b0, 16'hBEEF);
      run_word(1'b0, e, 6, -1, "word BEEF after reset");
   endtask

   task automatic test_back_to_back();
      logic [7:0] e1 [6];
      logic [7:0] e2 [6];
      e1 = '{8'h35, 8'h43, 8'h30, 8'h30, 8'h0D, 8'h0A};
      e2 = '{8'h37, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
      tick();
      send_word(1'b0, 16'h00C5);
      run_word(1'b0, e1, 6, -1, "b2b first");
      send_word(1'b0, 16'h0007);
      checks++;
      if (drop_a !== 1'b0) begin
         errors++;
         $display("FAIL b2b accept: dropped=%b required 0", drop_a);
      end
      run_word(1'b0, e2, 6, -1, "b2b second");
   endtask

   initial begin
      tick();
      tick();
      test_reset();
      test_word();
      test_no_crlf();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
